// File: rtl/mem_rd_pkg.sv
// mem_rd_pkg
//   Shared definitions for the memory read server: beat geometry, FSM state
//   and client-id enums, plus a helper that builds the byte-keep mask used on
//   the final (partial) beat of a transfer.
package mem_rd_pkg;

  localparam int MEM_DATA_BUS   = 128;
  localparam int BYTES_PER_BEAT = MEM_DATA_BUS / 8;
  localparam int BEAT_IDX_W     = $clog2(BYTES_PER_BEAT);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  typedef enum logic {
    CLI_PIC = 1'b0,
    CLI_WGT = 1'b1
  } client_t;

  // Byte-keep mask for the last beat: a zero tail means the beat is full.
  function automatic logic [MEM_DATA_BUS-1:0] tail_keep(input logic [BEAT_IDX_W-1:0] tail);
    logic [MEM_DATA_BUS-1:0] m;
    m = '0;
    for (int i = 0; i < BYTES_PER_BEAT; i++) begin
      if ((tail == '0) || (i < int'(tail))) begin
        m[i*8 +: 8] = 8'hFF;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_rd_server_if.sv
// mem_rd_server_if
//   One client's read channel of the mem_intf_read protocol.
//   Client -> server : mem_req, mem_start_addr, mem_size_bytes
//   Server -> client : mem_gnt, mem_valid, mem_data, mem_last_valid
//   modport master is the client (accelerator port), slave is the server.
interface mem_rd_server_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int SIZE_WIDTH = 16
);

  logic                                mem_req;
  logic [ADDR_WIDTH-1:0]               mem_start_addr;
  logic [SIZE_WIDTH-1:0]               mem_size_bytes;
  logic                                mem_gnt;
  logic                                mem_valid;
  logic [mem_rd_pkg::MEM_DATA_BUS-1:0] mem_data;
  logic                                mem_last_valid;

  modport master (
    output mem_req, mem_start_addr, mem_size_bytes,
    input  mem_gnt, mem_valid, mem_data, mem_last_valid
  );

  modport slave (
    input  mem_req, mem_start_addr, mem_size_bytes,
    output mem_gnt, mem_valid, mem_data, mem_last_valid
  );

endinterface

// File: rtl/mem_rd_rr_arb.sv
// mem_rd_rr_arb
//   Two-requester round-robin arbiter. A lone requester always wins; when
//   both request, the one not granted last wins. The pointer favours pic out
//   of reset and moves only when the grant is actually taken.
//   Ports: clk, rst_n (async active-low), req[1:0] (bit0 pic, bit1 wgt),
//          accept (grant taken this cycle), sel[1:0] one-hot winner.
module mem_rd_rr_arb
  import mem_rd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] sel
);

  client_t favour_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      favour_q <= CLI_PIC;
    end else if (accept) begin
      favour_q <= sel[0] ? CLI_WGT : CLI_PIC;
    end
  end

  always_comb begin
    sel = req;
    if (req == 2'b11) begin
      sel = (favour_q == CLI_PIC) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_rd_server.sv
// mem_rd_server
//   Memory-side responder for the wgt and pic read clients of the FC
//   accelerator. Picks one request round-robin, reads ceil(size/16) words from
//   a 1-cycle-latency SRAM and streams them back as 128-bit beats, zeroing the
//   bytes past the requested size on the final beat.
//   Ports: clk, rst_n (async active-low); wgt, pic (client channels, slave
//          side); sram_rd_en/sram_addr/sram_rdata (SRAM word port);
//          rd_busy (transfer in progress); rd_err (bound check only).
//   Optional: define MEM_RD_BOUND_CHK_EN to reject transfers running past the
//          top of the SRAM; they get one zero beat with rd_err and no read.
//          Without it addresses simply wrap.
module mem_rd_server
  import mem_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int SIZE_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  mem_rd_server_if.slave                   wgt,
  mem_rd_server_if.slave                   pic,
  output logic                             sram_rd_en,
  output logic [ADDR_WIDTH-BEAT_IDX_W-1:0] sram_addr,
  input  logic [MEM_DATA_BUS-1:0]          sram_rdata,
  output logic                             rd_busy
`ifdef MEM_RD_BOUND_CHK_EN
  ,
  output logic                             rd_err
`endif
);

  localparam int WORD_W = ADDR_WIDTH - BEAT_IDX_W;

  state_t                  state_q, state_d;
  logic [1:0]              req, sel;
  logic                    accept;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [SIZE_WIDTH-1:0]   sel_size;
  logic [SIZE_WIDTH:0]     sel_beats;
  logic [WORD_W-1:0]       sel_word;
  logic                    bound_err;

  client_t                 client_q;
  logic [WORD_W-1:0]       word_q;
  logic [SIZE_WIDTH-1:0]   left_q;
  logic [BEAT_IDX_W-1:0]   tail_q;
  logic                    zero_q, err_q, gnt_q, valid_q;
  logic                    last;
  logic [MEM_DATA_BUS-1:0] beat_data, out_data;

  assign req    = {wgt.mem_req, pic.mem_req};
  assign accept = (state_q == IDLE) && (req != 2'b00);

  mem_rd_rr_arb u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .accept (accept),
    .sel    (sel)
  );

  assign sel_addr = sel[1] ? wgt.mem_start_addr : pic.mem_start_addr;
  assign sel_size = sel[1] ? wgt.mem_size_bytes : pic.mem_size_bytes;
  assign sel_word = WORD_W'(sel_addr >> BEAT_IDX_W);

  // Size 0 still produces one (all-zero) beat.
  assign sel_beats = (sel_size == '0) ? (SIZE_WIDTH+1)'(1)
                   : (({1'b0, sel_size} + (SIZE_WIDTH+1)'(BYTES_PER_BEAT-1)) >> BEAT_IDX_W);

`ifdef MEM_RD_BOUND_CHK_EN
  logic [SIZE_WIDTH+1:0] end_word;
  assign end_word  = (SIZE_WIDTH+2)'(sel_word) + (SIZE_WIDTH+2)'(sel_beats);
  assign bound_err = end_word > (SIZE_WIDTH+2)'(2**WORD_W);
`else
  assign bound_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    if (left_q == '0) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transfer context is captured at the grant; valid trails the READ
  // state by one cycle to match the SRAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      client_q <= CLI_PIC;
      word_q   <= '0;
      left_q   <= '0;
      tail_q   <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      gnt_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      gnt_q   <= accept;
      valid_q <= (state_q == READ);
      if (accept) begin
        client_q <= sel[1] ? CLI_WGT : CLI_PIC;
        word_q   <= sel_word;
        left_q   <= bound_err ? '0 : SIZE_WIDTH'(sel_beats - 1'b1);
        tail_q   <= sel_size[BEAT_IDX_W-1:0];
        zero_q   <= (sel_size == '0);
        err_q    <= bound_err;
      end else if ((state_q == READ) && (left_q != '0)) begin
        left_q <= left_q - 1'b1;
        word_q <= word_q + 1'b1;
      end
    end
  end

  assign sram_rd_en = (state_q == READ) && !err_q;
  assign sram_addr  = sram_rd_en ? word_q : '0;
  assign rd_busy    = (state_q != IDLE);
  assign last       = valid_q && (state_q == DRAIN);

  always_comb begin
    beat_data = sram_rdata;
    if (zero_q || err_q) begin
      beat_data = '0;
    end else if (last) begin
      beat_data = sram_rdata & tail_keep(tail_q);
    end
    out_data = valid_q ? beat_data : '0;
  end

`ifdef MEM_RD_BOUND_CHK_EN
  assign rd_err = last && err_q;
`endif

  assign pic.mem_gnt        = gnt_q   && (client_q == CLI_PIC);
  assign pic.mem_valid      = valid_q && (client_q == CLI_PIC);
  assign pic.mem_last_valid = last    && (client_q == CLI_PIC);
  assign pic.mem_data       = (client_q == CLI_PIC) ? out_data : '0;
  assign wgt.mem_gnt        = gnt_q   && (client_q == CLI_WGT);
  assign wgt.mem_valid      = valid_q && (client_q == CLI_WGT);
  assign wgt.mem_last_valid = last    && (client_q == CLI_WGT);
  assign wgt.mem_data       = (client_q == CLI_WGT) ? out_data : '0;

endmodule

// File: tb/tb_mem_rd_server.sv
// tb_mem_rd_server
//   Randomized self-checking bench for mem_rd_server. A behavioural model
//   turns each request scenario into an expected per-cycle timeline (grant,
//   SRAM reads, beats, masking, arbitration order) which is compared against
//   the DUT every cycle. Honours MEM_RD_BOUND_CHK_EN like the design.
module tb_mem_rd_server;

  localparam int B_PGNT = 8, B_PVAL = 7, B_PLAST = 6, B_WGNT = 5, B_WVAL = 4,
                 B_WLAST = 3, B_RDEN = 2, B_BUSY = 1, B_ERR = 0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sram_rd_en;
  logic [7:0]   sram_addr;
  logic [127:0] sram_rdata;
  logic         rd_busy;
`ifdef MEM_RD_BOUND_CHK_EN
  logic         rd_err;
`endif

  mem_rd_server_if pic_if ();
  mem_rd_server_if wgt_if ();

  mem_rd_server dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wgt        (wgt_if),
    .pic        (pic_if),
    .sram_rd_en (sram_rd_en),
    .sram_addr  (sram_addr),
    .sram_rdata (sram_rdata),
    .rd_busy    (rd_busy)
`ifdef MEM_RD_BOUND_CHK_EN
    ,
    .rd_err     (rd_err)
`endif
  );

  always #5 clk = ~clk;

  logic [127:0] mem [256];

  // SRAM model: one-cycle read latency.
  always @(posedge clk) begin
    if (sram_rd_en) sram_rdata <= mem[sram_addr];
  end

  int errors = 0;
  int checks = 0;
  bit favourPic = 1'b1;

  logic [8:0]   expCtl [64];
  logic [127:0] expPicData [64];
  logic [127:0] expWgtData [64];
  logic [7:0]   expAddr [64];

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] obsCtl();
    logic [8:0] c;
    c = {pic_if.mem_gnt, pic_if.mem_valid, pic_if.mem_last_valid,
         wgt_if.mem_gnt, wgt_if.mem_valid, wgt_if.mem_last_valid,
         sram_rd_en, rd_busy, 1'b0};
`ifdef MEM_RD_BOUND_CHK_EN
    c[B_ERR] = rd_err;
`endif
    return c;
  endfunction

  // Place one transfer whose grant lands at relative cycle g; returns the
  // cycle of its last beat.
  function automatic int placeTransfer(input bit isWgt, input int g,
                                       input logic [11:0] addr, input logic [15:0] size);
    int n, sw, tail;
    bit err;
    logic [127:0] d;
    n    = (size == 0) ? 1 : (int'(size) + 15) / 16;
    sw   = int'(addr) / 16;
    tail = int'(size) % 16;
    err  = 1'b0;
`ifdef MEM_RD_BOUND_CHK_EN
    err = (sw + n) > 256;
`endif
    expCtl[g][isWgt ? B_WGNT : B_PGNT] = 1'b1;
    if (err) begin
      expCtl[g][B_BUSY]   = 1'b1;
      expCtl[g+1][B_BUSY] = 1'b1;
      expCtl[g+1][isWgt ? B_WVAL : B_PVAL]   = 1'b1;
      expCtl[g+1][isWgt ? B_WLAST : B_PLAST] = 1'b1;
      expCtl[g+1][B_ERR]  = 1'b1;
      return g + 1;
    end
    for (int i = 0; i < n; i++) begin
      expCtl[g+i][B_RDEN]   = 1'b1;
      expCtl[g+i][B_BUSY]   = 1'b1;
      expAddr[g+i]          = 8'((sw + i) % 256);
      expCtl[g+i+1][B_BUSY] = 1'b1;
      expCtl[g+i+1][isWgt ? B_WVAL : B_PVAL] = 1'b1;
      d = (size == 0) ? 128'd0 : mem[(sw + i) % 256];
      if ((i == n - 1) && (tail != 0)) begin
        for (int b = tail; b < 16; b++) d[b*8 +: 8] = 8'h00;
      end
      if (isWgt) expWgtData[g+i+1] = d;
      else       expPicData[g+i+1] = d;
    end
    expCtl[g+n][isWgt ? B_WLAST : B_PLAST] = 1'b1;
    return g + n;
  endfunction

  task automatic applyStimulus(input bit usePic, input bit useWgt,
                               input logic [11:0] picAddr, input logic [15:0] picSize,
                               input logic [11:0] wgtAddr, input logic [15:0] wgtSize,
                               input string name);
    bit firstWgt;
    int e, t;
    logic [8:0] c;
    for (int i = 0; i < 64; i++) begin
      expCtl[i] = '0; expPicData[i] = '0; expWgtData[i] = '0; expAddr[i] = '0;
    end
    firstWgt = (usePic && useWgt) ? !favourPic : useWgt;
    e = placeTransfer(firstWgt, 1, firstWgt ? wgtAddr : picAddr, firstWgt ? wgtSize : picSize);
    favourPic = firstWgt;
    if (usePic && useWgt) begin
      e = placeTransfer(!firstWgt, e + 2, firstWgt ? picAddr : wgtAddr, firstWgt ? picSize : wgtSize);
      favourPic = !firstWgt;
    end
    t = e + 1;
    @(negedge clk);
    checkOutput({name, " idle ctl"}, 128'(obsCtl()), 128'd0);
    pic_if.mem_req = usePic; pic_if.mem_start_addr = picAddr; pic_if.mem_size_bytes = picSize;
    wgt_if.mem_req = useWgt; wgt_if.mem_start_addr = wgtAddr; wgt_if.mem_size_bytes = wgtSize;
    for (int k = 1; k <= t; k++) begin
      @(negedge clk);
      c = obsCtl();
      checkOutput($sformatf("%s ctl@%0d", name, k), 128'(c), 128'(expCtl[k]));
      checkOutput($sformatf("%s pic_data@%0d", name, k), pic_if.mem_data, expPicData[k]);
      checkOutput($sformatf("%s wgt_data@%0d", name, k), wgt_if.mem_data, expWgtData[k]);
      if (expCtl[k][B_RDEN])
        checkOutput($sformatf("%s sram_addr@%0d", name, k), 128'(sram_addr), 128'(expAddr[k]));
      if (c[B_PGNT]) pic_if.mem_req = 1'b0;
      if (c[B_WGNT]) wgt_if.mem_req = 1'b0;
    end
    pic_if.mem_req = 1'b0;
    wgt_if.mem_req = 1'b0;
  endtask

  task automatic resetMidTransfer();
    @(negedge clk);
    pic_if.mem_req = 1'b1; pic_if.mem_start_addr = 12'h100; pic_if.mem_size_bytes = 16'd64;
    @(negedge clk);
    pic_if.mem_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async reset ctl", 128'(obsCtl()), 128'd0);
    checkOutput("async reset pic_data", pic_if.mem_data, 128'd0);
    checkOutput("async reset sram_addr", 128'(sram_addr), 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    favourPic = 1'b1;
    @(negedge clk);
    checkOutput("post reset ctl", 128'(obsCtl()), 128'd0);
  endtask

  initial begin
    logic [11:0] pa, wa;
    logic [15:0] ps, ws;
    int mode;
    pic_if.mem_req = 1'b0; pic_if.mem_start_addr = '0; pic_if.mem_size_bytes = '0;
    wgt_if.mem_req = 1'b0; wgt_if.mem_start_addr = '0; wgt_if.mem_size_bytes = '0;
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    checkOutput("reset ctl", 128'(obsCtl()), 128'd0);
    checkOutput("reset pic_data", pic_if.mem_data, 128'd0);
    checkOutput("reset wgt_data", wgt_if.mem_data, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1, 1, 12'h200, 16'd40, 12'h300, 16'd17, "pair1");
    applyStimulus(1, 1, 12'h010, 16'd16, 12'h020, 16'd33, "pair2");
    applyStimulus(1, 0, 12'h040, 16'd32, 12'h000, 16'd0, "single_pic");
    applyStimulus(0, 1, 12'h000, 16'd0, 12'h000, 16'd20, "partial_wgt");
    applyStimulus(1, 0, 12'h080, 16'd0, 12'h000, 16'd0, "zero_size");
    applyStimulus(1, 0, 12'hFF0, 16'd32, 12'h000, 16'd0, "top_bound");
    applyStimulus(0, 1, 12'h000, 16'd0, 12'hFE7, 16'd48, "top_bound_wgt");

    for (int r = 0; r < 24; r++) begin
      mode = $urandom_range(0, 2);
      pa = 12'($urandom_range(0, 4095));
      wa = 12'($urandom_range(0, 4095));
      ps = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 200)) : 16'($urandom_range(0, 48));
      ws = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 200)) : 16'($urandom_range(0, 48));
      applyStimulus(mode != 1, mode != 0, pa, ps, wa, ws, $sformatf("rand%0d", r));
    end

    resetMidTransfer();
    applyStimulus(1, 1, 12'h0A0, 16'd24, 12'h0B0, 16'd8, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_rd_server.md
Name: mem_rd_server

Overview:
- Memory-side responder for the mem_intf_read client protocol.
- Serves the two read clients of the FC accelerator: the weight port (wgt) and the picture/data port (pic).
- Arbitrates between them round-robin, issues the request, and streams the requested bytes from a 1-cycle-latency SRAM as MEM_DATA_BUS-wide beats.
- Sits between the accelerator read interfaces and the local SRAM.

Parameters:
- ADDR_WIDTH, 12: byte address width of mem_start_addr.
- MEM_DATA_BUS, 128: data beat width in bits; BYTES_PER_BEAT = MEM_DATA_BUS/8.
- SIZE_WIDTH, 16: width of mem_size_bytes.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- wgt_mem_req / pic_mem_req  in  1  client request; held until grant.
- wgt_mem_start_addr / pic_mem_start_addr  in  ADDR_WIDTH  byte start address; low log2(BYTES_PER_BEAT) bits ignored.
- wgt_mem_size_bytes / pic_mem_size_bytes  in  SIZE_WIDTH  bytes requested.
- wgt_mem_gnt / pic_mem_gnt  out  1  one-cycle request-accept pulse.
- wgt_mem_valid / pic_mem_valid  out  1  data beat valid.
- wgt_mem_data / pic_mem_data  out  MEM_DATA_BUS  beat data, byte 0 in [7:0]; zero when not valid.
- wgt_mem_last_valid / pic_mem_last_valid  out  1  final beat of the transfer, coincident with valid.
- sram_rd_en  out  1  SRAM read strobe.
- sram_addr  out  ADDR_WIDTH-log2(BYTES_PER_BEAT)  SRAM word address.
- sram_rdata  in  MEM_DATA_BUS  SRAM data, valid the cycle after sram_rd_en.
- rd_busy  out  1  transfer in progress.

Behaviour:
- Reset: every output is 0. State is IDLE. The round-robin pointer favours pic.
- States:
  - IDLE: req sampled. If any req is high, go to READ and register gnt.
  - READ: issue one SRAM word read per cycle for N cycles.
  - DRAIN: one cycle for the last SRAM return, then back to IDLE.
- Beat count: N = ceil(size/BYTES_PER_BEAT). size=0 is treated as N=1 with an all-zero beat.
- Timing (cycle 0 = req sampled high in IDLE):
  - Cycle 1: gnt=1 for the selected client; start address and size latched; sram_rd_en=1 with sram_addr = start word.
  - Cycles 1..N: sram_rd_en=1, word address incrementing by 1.
  - Cycles 2..N+1: valid=1 with data = sram_rdata. last_valid=1 at cycle N+1.
  - Cycle N+2: IDLE; rd_busy=0.
- rd_busy is 1 from cycle 1 through cycle N+1.
- Arbitration:
  - Single requester is granted.
  - Simultaneous requests: grant the client not granted last. The pointer updates on each gnt.
- Request handling:
  - req, addr and size are ignored outside IDLE; the client drops req after gnt.
  - A req still high in IDLE (cycle N+2) is a new request. The earliest back-to-back gnt is at cycle N+3.
- Final-beat masking: on the final beat, bytes at index >= size mod BYTES_PER_BEAT (when nonzero) are forced to 0.
- No backpressure: a client must accept every valid beat.
- Address arithmetic: word address wraps modulo 2^(ADDR_WIDTH-log2(BYTES_PER_BEAT)).
- Outputs to the non-selected client remain 0.
- Reset mid-transfer aborts immediately. All outputs go to 0; the client must re-request.

Optional Feature:
- MEM_RD_BOUND_CHK_EN defined:
  - At gnt, check start_word + N > 2^(ADDR_WIDTH-log2(BYTES_PER_BEAT)).
  - If the check fails: gnt is given, no SRAM read is issued, and a single zero beat is sent with valid=last_valid=1 at cycle 2.
  - Extra output rd_err, 1 bit, pulses with that beat.
- Undefined: no check, addresses wrap, and rd_err is absent.

Decomposition:
- Package mem_rd_pkg: MEM_DATA_BUS, BYTES_PER_BEAT, BEAT_IDX_W, state enum {IDLE, READ, DRAIN}, client-id enum {CLI_PIC, CLI_WGT}.
- Sub-module mem_rd_rr_arb: two-requester round-robin arbiter with registered pointer; inputs req[1:0] and accept; outputs one-hot sel.

Test Plan:
- Single transfer: pic req, addr 0x040, size 32 -> pic_gnt at cycle 1; valid at cycles 2-3 carrying SRAM words 4 and 5; last_valid at cycle 3; wgt outputs stay 0.
- Partial final beat: wgt size 20, addr 0x000 -> 2 beats; beat 1 bytes 0-3 equal SRAM word 1 bytes 0-3, bytes 4-15 are 0.
- Simultaneous requests after reset: pic and wgt both high -> pic served first; wgt_gnt at cycle N+3; a third simultaneous pair serves pic again.
- Zero size: pic size 0 -> gnt at cycle 1, then a single zero beat with valid=last_valid=1 at cycle 2.
- Reset mid-transfer: rst_n low at cycle 3 of a 4-beat read -> all outputs 0 asynchronously. After release, state is IDLE and a new request is granted normally.
- Bound check (MEM_RD_BOUND_CHK_EN): addr 0xFF0, size 32 -> rd_err=1 with one zero last beat and no sram_rd_en. With the macro undefined, the read wraps to words 0xFF and 0x00.
